// File: rtl/kv_arbiter_if.sv
// kv_arbiter_if: bundle of the two requester ports, the store port and arbiter status; master = requesters+store side, slave = arbiter
interface kv_arbiter_if;
  logic s0_cyc, s0_stb, s0_we, s0_ack, s0_err;
  logic [15:0] s0_adr, s0_dat_w, s0_key, s0_dat_r;
  logic s1_cyc, s1_stb, s1_we, s1_ack, s1_err;
  logic [15:0] s1_adr, s1_dat_w, s1_key, s1_dat_r;
  logic m_cyc, m_stb, m_we, m_ack;
  logic [15:0] m_adr, m_dat_w, m_key, m_dat_r;
  logic [1:0] grant;
  logic busy;
  modport master (
    output s0_cyc, s0_stb, s0_we, s0_adr, s0_dat_w, s0_key,
    output s1_cyc, s1_stb, s1_we, s1_adr, s1_dat_w, s1_key,
    output m_ack, m_dat_r,
    input s0_ack, s0_err, s0_dat_r, s1_ack, s1_err, s1_dat_r,
    input m_cyc, m_stb, m_we, m_adr, m_dat_w, m_key, grant, busy
  );
  modport slave (
    input s0_cyc, s0_stb, s0_we, s0_adr, s0_dat_w, s0_key,
    input s1_cyc, s1_stb, s1_we, s1_adr, s1_dat_w, s1_key,
    input m_ack, m_dat_r,
    output s0_ack, s0_err, s0_dat_r, s1_ack, s1_err, s1_dat_r,
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_key, grant, busy
  );
endinterface

// File: rtl/kv_arbiter.sv
// kv_arbiter: round-robin arbiter sharing one KV store between two requesters with a watchdog; ports sys_clk, sys_rst, bus (kv_arbiter_if.slave)
module kv_arbiter #(
  parameter int TIMEOUT = 15,
  parameter logic [15:0] TO_DATA = 16'hFFFF
) (
  input logic sys_clk,
  input logic sys_rst,
  kv_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic last, own, pick, p0, p1, done;
  logic [7:0] timer;
  logic [15:0] rdat;
  always_comb begin
    p0 = bus.s0_cyc & bus.s0_stb;
    p1 = bus.s1_cyc & bus.s1_stb;
    pick = (p0 & p1) ? ~last : p1;
    done = bus.m_ack | (timer == 8'(TIMEOUT));
    rdat = bus.m_ack ? bus.m_dat_r : TO_DATA;
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      last <= 1'b1;
      own <= 1'b0;
      timer <= '0;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      bus.s0_ack <= 1'b0;
      bus.s1_ack <= 1'b0;
      bus.s0_err <= 1'b0;
      bus.s1_err <= 1'b0;
      bus.s0_dat_r <= '0;
      bus.s1_dat_r <= '0;
      bus.m_cyc <= 1'b0;
      bus.m_stb <= 1'b0;
      bus.m_we <= 1'b0;
      bus.m_adr <= '0;
      bus.m_dat_w <= '0;
      bus.m_key <= '0;
    end else
      case (state)
        IDLE:
          if (p0 | p1) begin
            own <= pick;
            last <= pick;
            bus.grant <= pick ? 2'b10 : 2'b01;
            bus.busy <= 1'b1;
            bus.m_cyc <= 1'b1;
            bus.m_stb <= 1'b1;
            bus.m_we <= pick ? bus.s1_we : bus.s0_we;
            bus.m_adr <= pick ? bus.s1_adr : bus.s0_adr;
            bus.m_dat_w <= pick ? bus.s1_dat_w : bus.s0_dat_w;
            bus.m_key <= pick ? bus.s1_key : bus.s0_key;
            state <= ISSUE;
          end
        ISSUE: begin
          bus.m_cyc <= 1'b0;
          bus.m_stb <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT:
          if (done) begin
            if (own) begin
              bus.s1_ack <= 1'b1;
              bus.s1_err <= ~bus.m_ack;
              bus.s1_dat_r <= rdat;
            end else begin
              bus.s0_ack <= 1'b1;
              bus.s0_err <= ~bus.m_ack;
              bus.s0_dat_r <= rdat;
            end
            state <= RESP;
          end else if (timer != 8'hFF) timer <= timer + 8'd1;
        RESP: begin
          bus.s0_ack <= 1'b0;
          bus.s1_ack <= 1'b0;
          bus.s0_err <= 1'b0;
          bus.s1_err <= 1'b0;
          bus.grant <= '0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_kv_arbiter.sv
// tb_kv_arbiter: table-driven and scoreboard bench for kv_arbiter with a behavioural store model
module tb_kv_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  kv_arbiter_if bus();
  kv_arbiter #(.TIMEOUT(15), .TO_DATA(16'hFFFF)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
  typedef struct {
    bit port;
    bit we;
    logic [15:0] adr, dat, key;
    int dly;
    logic [15:0] rdat, exp_d;
    bit exp_err;
    int exp_lat;
  } vec_t;
  typedef struct {
    bit port;
    logic [15:0] d;
    bit err;
  } sb_t;
  sb_t sb[$];
  sb_t e;
  logic [1:0] gq[$];
  logic [15:0] exp_dr[2];
  int n_chk = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int st_dly = 0;
  logic [15:0] st_dat = '0;
  int stb_cnt = 0;
  bit armed = 0;
  int cnt = 0;
  logic rec_we;
  logic [15:0] rec_adr, rec_dat, rec_key;
  logic [1:0] rec_grant;
  vec_t v[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_req(input bit port, input bit on, input bit we, input logic [15:0] adr, dat, key);
    if (port) begin
      bus.s1_cyc = on; bus.s1_stb = on; bus.s1_we = we;
      bus.s1_adr = adr; bus.s1_dat_w = dat; bus.s1_key = key;
    end else begin
      bus.s0_cyc = on; bus.s0_stb = on; bus.s0_we = we;
      bus.s0_adr = adr; bus.s0_dat_w = dat; bus.s0_key = key;
    end
  endtask
  // store model: ack st_dly WAIT cycles after the ISSUE strobe, never when st_dly < 0
  always @(negedge clk) begin
    bus.m_ack = 1'b0;
    if (rst) armed = 0;
    else if (armed) begin
      if (st_dly >= 0 && cnt == st_dly) begin
        bus.m_ack = 1'b1;
        bus.m_dat_r = st_dat;
        armed = 0;
      end
      cnt++;
    end
    if (bus.m_stb) begin
      armed = 1;
      cnt = 0;
      stb_cnt++;
      rec_we = bus.m_we; rec_adr = bus.m_adr; rec_dat = bus.m_dat_w; rec_key = bus.m_key;
      rec_grant = bus.grant;
      gq.push_back(bus.grant);
    end
  end
  always @(negedge clk)
    if (!rst && (bus.s0_ack || bus.s1_ack)) begin
      ack_cnt++;
      if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ack_both", {31'd0, bus.s0_ack & bus.s1_ack}, 0);
        chk("ack_port", {31'd0, bus.s1_ack}, {31'd0, e.port});
        chk("ack_dat_r", {16'd0, e.port ? bus.s1_dat_r : bus.s0_dat_r}, {16'd0, e.d});
        chk("ack_err", {31'd0, e.port ? bus.s1_err : bus.s0_err}, {31'd0, e.err});
        exp_dr[e.port] = e.d;
      end
    end
  task automatic run(input vec_t t);
    int lat;
    @(negedge clk);
    st_dly = t.dly; st_dat = t.rdat; stb_cnt = 0;
    sb.push_back('{t.port, t.exp_d, t.exp_err});
    set_req(t.port, 1, t.we, t.adr, t.dat, t.key);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.s0_ack || bus.s1_ack) && lat < 100);
    set_req(t.port, 0, 0, '0, '0, '0);
    chk("latency", lat, t.exp_lat);
    chk("stb_count", stb_cnt, 1);
    chk("m_we", {31'd0, rec_we}, {31'd0, t.we});
    chk("m_adr", {16'd0, rec_adr}, {16'd0, t.adr});
    chk("m_dat_w", {16'd0, rec_dat}, {16'd0, t.dat});
    chk("m_key", {16'd0, rec_key}, {16'd0, t.key});
    chk("grant_issue", {30'd0, rec_grant}, t.port ? 2 : 1);
    @(negedge clk);
    chk("grant_idle", {30'd0, bus.grant}, 0);
    chk("busy_idle", {31'd0, bus.busy}, 0);
    chk("s0_dat_r_held", {16'd0, bus.s0_dat_r}, {16'd0, exp_dr[0]});
    chk("s1_dat_r_held", {16'd0, bus.s1_dat_r}, {16'd0, exp_dr[1]});
  endtask
  initial begin
    int n, a0;
    exp_dr[0] = '0; exp_dr[1] = '0;
    bus.m_dat_r = '0;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    v[0] = '{0, 1, 16'h0000, 16'h1234, 16'h0042, 0, 16'h0001, 16'h0001, 0, 3};
    v[1] = '{1, 0, 16'h0003, 16'h0000, 16'h0000, 2, 16'hBEEF, 16'hBEEF, 0, 5};
    v[2] = '{0, 0, 16'h0007, 16'h0000, 16'h0000, 1, 16'h5555, 16'h5555, 0, 4};
    v[3] = '{0, 0, 16'h0009, 16'h0000, 16'h0000, -1, 16'h0000, 16'hFFFF, 1, 18};
    v[4] = '{1, 1, 16'h0000, 16'hCAFE, 16'h0077, 0, 16'h0002, 16'h0002, 0, 3};
    v[5] = '{0, 0, 16'h0004, 16'h0000, 16'h0000, 15, 16'hA5A5, 16'hA5A5, 0, 18};
    v[6] = '{1, 0, 16'h0005, 16'h0000, 16'h0000, 14, 16'h1111, 16'h1111, 0, 17};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", {30'd0, bus.grant}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_acks", {30'd0, bus.s0_ack, bus.s1_ack}, 0);
    chk("rst_errs", {30'd0, bus.s0_err, bus.s1_err}, 0);
    chk("rst_m_ctl", {29'd0, bus.m_cyc, bus.m_stb, bus.m_we}, 0);
    chk("rst_m_adr", {16'd0, bus.m_adr}, 0);
    chk("rst_dat_r", {bus.s0_dat_r, bus.s1_dat_r}, 0);
    for (int i = 0; i < 7; i++) run(v[i]);
    @(negedge clk);
    st_dly = -1; stb_cnt = 0;
    set_req(0, 1, 0, 16'h0009, '0, '0);
    n = 0;
    while (stb_cnt == 0 && n < 20) begin @(negedge clk); n++; end
    chk("rstw_stb_seen", stb_cnt, 1);
    repeat (3) @(negedge clk);
    chk("rstw_busy_wait", {31'd0, bus.busy}, 1);
    chk("rstw_grant_wait", {30'd0, bus.grant}, 1);
    rst = 1'b1;
    set_req(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("rstw_grant", {30'd0, bus.grant}, 0);
    chk("rstw_busy", {31'd0, bus.busy}, 0);
    chk("rstw_dat_r", {bus.s0_dat_r, bus.s1_dat_r}, 0);
    exp_dr[0] = '0; exp_dr[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    a0 = ack_cnt;
    repeat (20) @(negedge clk);
    chk("rstw_no_ack", ack_cnt, a0);
    st_dly = 0; st_dat = 16'h7777; stb_cnt = 0;
    gq.delete();
    for (int i = 0; i < 4; i++) sb.push_back('{i[0], 16'h7777, 0});
    set_req(0, 1, 1, 16'h0010, 16'h0101, 16'h0011);
    set_req(1, 1, 0, 16'h0020, '0, '0);
    n = 0; a0 = 0;
    while (a0 < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.s0_ack || bus.s1_ack) a0++;
    end
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    chk("tie_acks", a0, 4);
    chk("tie_stb_count", stb_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk("tie_grant_order", (i < gq.size()) ? {30'd0, gq[i]} : 32'hDEAD, i[0] ? 2 : 1);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("final_idle", {31'd0, bus.busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
